// File: rtl/bike_bram_seq_ctrl_if.sv
// Command and BRAM-port bundle for the BRAM sequencing controller.
// The master view belongs to the controller; the slave view belongs to the host and memory side.
interface bike_bram_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              ren_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] dout_a;
  logic              wen_a;
  logic              ren_b;
  logic              wen_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] din_b;

  modport master (
    input  start, op, src, dst, len, abort, dout_a,
    output busy, done, err, ren_a, addr_a, wen_a, ren_b, wen_b, addr_b, din_b
  );

  modport slave (
    output start, op, src, dst, len, abort, dout_a,
    input  busy, done, err, ren_a, addr_a, wen_a, ren_b, wen_b, addr_b, din_b
  );
endinterface

// File: rtl/bike_bram_seq_ctrl.sv
// BRAM region sequencer: CLEAR writes zeros to a region, COPY streams port A reads into port B writes.
// Forward-overlapping copies are rejected so a word is never read after it has been overwritten.
module bike_bram_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  bike_bram_seq_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_C  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state, w_state;
  logic              r_op, w_op;
  logic [ADDR_W-1:0] r_src, w_src;
  logic [ADDR_W-1:0] r_dst, w_dst;
  logic [ADDR_W:0]   r_len, w_len;
  logic [ADDR_W:0]   r_rd_cnt, w_rd_cnt;
  logic [ADDR_W:0]   r_wr_cnt, w_wr_cnt;
  logic              r_ren_a, w_ren_a;
  logic [ADDR_W-1:0] r_addr_a, w_addr_a;
  logic              r_wen_b, w_wen_b;
  logic [ADDR_W-1:0] r_addr_b, w_addr_b;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic [ADDR_W-1:0] w_diff;
  logic              w_overlap;

  // A destination 1..len-1 words ahead of the source would overwrite words not yet read.
  assign w_diff    = bus.dst - bus.src;
  assign w_overlap = (w_diff != ZERO_A) && ({1'b0, w_diff} < bus.len);

  // Next-state, command latch and next BRAM control values
  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_src    = r_src;
    w_dst    = r_dst;
    w_len    = r_len;
    w_rd_cnt = r_rd_cnt;
    w_wr_cnt = r_wr_cnt;
    w_ren_a  = 1'b0;
    w_addr_a = ZERO_A;
    w_wen_b  = 1'b0;
    w_addr_b = ZERO_A;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_op     = bus.op;
          w_src    = bus.src;
          w_dst    = bus.dst;
          w_len    = bus.len;
          w_rd_cnt = ZERO_C;
          w_wr_cnt = ZERO_C;
          if (bus.len == ZERO_C) begin
            w_state = S_FIN;
            w_done  = 1'b1;
          end else if (bus.op && w_overlap) begin
            w_err = 1'b1;
          end else begin
            w_state = S_RUN;
            if (bus.op) begin
              w_ren_a  = 1'b1;
              w_addr_a = bus.src;
              w_rd_cnt = ONE_C;
            end else begin
              w_wen_b  = 1'b1;
              w_addr_b = bus.dst;
              w_wr_cnt = ONE_C;
            end
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state = S_IDLE;
        end else if (r_op) begin
          // Each write consumes the word read in the previous cycle.
          if (r_ren_a) begin
            w_wen_b  = 1'b1;
            w_addr_b = r_dst + r_wr_cnt[ADDR_W-1:0];
            w_wr_cnt = r_wr_cnt + ONE_C;
          end else begin
            w_wr_cnt = r_wr_cnt;
          end
          if (r_rd_cnt < r_len) begin
            w_ren_a  = 1'b1;
            w_addr_a = r_src + r_rd_cnt[ADDR_W-1:0];
            w_rd_cnt = r_rd_cnt + ONE_C;
          end else begin
            w_state = S_DRAIN;
          end
        end else begin
          if (r_wr_cnt < r_len) begin
            w_wen_b  = 1'b1;
            w_addr_b = r_dst + r_wr_cnt[ADDR_W-1:0];
            w_wr_cnt = r_wr_cnt + ONE_C;
          end else begin
            w_state = S_FIN;
            w_done  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_FIN;
          w_done  = 1'b1;
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state == S_RUN) || (w_state == S_DRAIN);
  end

  // State, latched command and registered BRAM controls/status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_op     <= 1'b0;
      r_src    <= ZERO_A;
      r_dst    <= ZERO_A;
      r_len    <= ZERO_C;
      r_rd_cnt <= ZERO_C;
      r_wr_cnt <= ZERO_C;
      r_ren_a  <= 1'b0;
      r_addr_a <= ZERO_A;
      r_wen_b  <= 1'b0;
      r_addr_b <= ZERO_A;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_op     <= w_op;
      r_src    <= w_src;
      r_dst    <= w_dst;
      r_len    <= w_len;
      r_rd_cnt <= w_rd_cnt;
      r_wr_cnt <= w_wr_cnt;
      r_ren_a  <= w_ren_a;
      r_addr_a <= w_addr_a;
      r_wen_b  <= w_wen_b;
      r_addr_b <= w_addr_b;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.ren_a  = r_ren_a;
  assign bus.addr_a = r_addr_a;
  assign bus.wen_a  = 1'b0;
  assign bus.ren_b  = r_wen_b;
  assign bus.wen_b  = r_wen_b;
  assign bus.addr_b = r_addr_b;
  // Read data passes straight through to the write port; CLEAR forces zeros.
  assign bus.din_b  = r_op ? bus.dout_a : {DATA_W{1'b0}};

endmodule
